sram_dp_param: RTL
==================

Name: sram_dp_param

Overview:
Parametrised simple-dual-port synchronous SRAM. It is the next-generation replacement for the 8-bit bidirectional-bus single-port RAM.
- Separate write and read ports, byte-lane write enables and a registered read with a valid strobe.
- Configurable read-during-write policy.
- Optional hardware clear sequence after reset, with a ready flag.
- Sits between datapath/controller blocks and on-chip storage; no tristate bus.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 8, address width
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RDW_MODE, 0, same-address read/write in one cycle: 0 = return old data, 1 = return new (write-through) data
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before asserting ready; 0 = ready immediately, contents undefined

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/8  byte-lane enables; bit i covers wr_data[8i+7:8i]
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  one-cycle strobe: rd_data is valid
ready  output  1  high when user requests are accepted

Behaviour:
- Reset, sampled on posedge with rst_n=0:
  - rd_data=0, rd_valid=0, ready=0, clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes all-zero to mem[cnt], then cnt++.
  - When cnt==DEPTH-1 the final word is written and the next state is IDLE.
  - Duration is exactly DEPTH cycles. ready rises on the first IDLE cycle.
- ready is registered: ready=1 iff state==IDLE.
- While ready=0, wr_en and rd_en are ignored: no array write, no rd_valid.
- Reset asserted mid-CLEAR: the counter returns to 0 and the clear restarts from word 0 after rst_n rises.
- IDLE, write:
  - On posedge with wr_en=1, each lane i with wr_be[i]=1 updates mem[wr_addr] lane i. Other lanes are unchanged.
  - wr_be all-zero means no change.
- IDLE, read:
  - On posedge with rd_en=1, rd_data takes mem[rd_addr] and rd_valid=1 in the following cycle. Latency is 1 cycle.
  - rd_valid is 0 in any cycle not preceded by an accepted read.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back reads give rd_valid high on consecutive cycles.
- Same cycle, same address (wr_en & rd_en & wr_addr==rd_addr):
  - RDW_MODE=0: rd_data is the pre-write word.
  - RDW_MODE=1: rd_data is the merged word, i.e. new bytes on enabled lanes and old bytes elsewhere.
  - The write always completes.
- Different addresses on the same cycle: both operations are independent.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write: ignored.
  - Read: returns 0 with rd_valid=1.
- No address wrap; addresses are absolute.
- Array inference: one write port, one synchronous read port. No reset of the array except through CLEAR.

Decomposition:
- Package sram_pkg:
  - Localparams RDW_OLD=0 and RDW_NEW=1.
  - FSM state encoding ST_CLEAR, ST_IDLE.
  - Function for byte-lane merge (old word, new word, be -> merged word).
- One sub-module, sram_clear_seq: clear counter and FSM.
  - Outputs: clear write enable, clear address, ready.
  - The top level muxes the clear write over the user write port and owns the array and read logic.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=256 -> ready=0 for exactly 256 cycles after rst_n rises, then 1; reading addr 0x00, 0x7F and 0xFF returns 0x00 with rd_valid one cycle later.
- DATA_W=16: write 0xABCD to addr 5 with be=2'b11, then 0x1234 with be=2'b01 -> read addr 5 returns 0xAB34; a write with be=2'b00 leaves 0xAB34.
- Same-cycle write 0x55 / read addr 3, where mem[3]=0xAA -> RDW_MODE=0 gives rd_data=0xAA, RDW_MODE=1 gives 0x55; the next read gives 0x55 in both modes.
- wr_en/rd_en pulsed while ready=0 (during CLEAR) -> rd_valid stays 0 and the target word reads 0x00 after ready; rst_n pulsed low at clear cycle 100 -> ready rises 256 cycles after the second rst_n release.
- DEPTH=200, ADDR_W=8: write 0x77 to addr 210 then read addr 210 -> rd_data=0x00, rd_valid=1; addr 199 write/read round-trips 0x77.
- Streaming reads of addr 0..15 on 16 consecutive cycles -> rd_valid high for 16 consecutive cycles with data matching the preloaded pattern, delayed 1 cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM: read-during-write
// policy codes, clear-sequencer state encoding and the byte-lane merge.
package sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest data word the lane-merge helper handles; callers zero-extend and slice.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } sram_state_e;

  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every word once with a zero write, then
// parks in IDLE and raises ready.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
    // ready follows the state it is entering so it rises on the first IDLE cycle
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state_q <= ST_CLEAR;
      else                     state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;
  assign ready    = ready_q;

endmodule

// File: rtl/sram_dp_param.sv
// Simple-dual-port synchronous SRAM with byte-lane writes, registered read,
// selectable read-during-write policy and optional clear-after-reset.
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                ready
);

  localparam int               BE_W    = DATA_W / 8;
  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready_i;

  sram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready_i)
  );

  logic wr_in_range, rd_in_range, wr_acc, rd_acc, same_addr;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_acc      = rst_n & ready_i & wr_en & wr_in_range;
  assign rd_acc      = rst_n & ready_i & rd_en;
  assign same_addr   = wr_acc & (wr_addr == rd_addr);

  // The clear sequence owns the single write port until ready
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;

  always_comb begin
    mem_we    = wr_acc;
    mem_widx  = wr_addr[IDX_W-1:0];
    mem_wdata = wr_data;
    mem_wbe   = wr_be;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_widx  = clr_addr[IDX_W-1:0];
      mem_wdata = '0;
      mem_wbe   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_wbe[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0]     rd_word;
  logic [MAX_DATA_W-1:0] merged_wide;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_word     = mem[rd_addr[IDX_W-1:0]];
    merged_wide = lane_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be));
    rd_valid_d  = rd_acc;
    rd_data_d   = rd_data_q;
    if (rd_acc) begin
      if (!rd_in_range)                          rd_data_d = '0;
      else if (RDW_MODE == RDW_NEW && same_addr) rd_data_d = merged_wide[DATA_W-1:0];
      else                                       rd_data_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_i;

endmodule
